// File: rtl/tile_pwr_seq_pkg.sv
// Shared types and width helpers for the tile power sequencer.
package tile_pwr_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UP_CLK = 3'd1,
    UP_RST = 3'd2,
    DN_ISO = 3'd3,
    DN_RST = 3'd4
  } pwr_state_e;

  typedef struct packed {
    logic on;
    logic timeout;
  } tile_stat_t;

  // Counter wide enough for the largest cycle parameter with one spare bit.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tile_pwr_sequencer_if.sv
// Per-tile request/status bundle between the chip control logic and the sequencer.
interface tile_pwr_sequencer_if
  import tile_pwr_seq_pkg::*;
#(
  parameter int NumTiles = 16
);
  // Level semantics throughout: en_req_i and iso_ack_i are sampled every cycle,
  // timeout_clr_i is a one-cycle pulse, every output is a registered level.
  logic [NumTiles-1:0] en_req_i;
  logic [NumTiles-1:0] iso_ack_i;
  logic [NumTiles-1:0] timeout_clr_i;
  logic [NumTiles-1:0] tile_clk_en_o;
  logic [NumTiles-1:0] tile_rst_no;
  logic [NumTiles-1:0] tile_iso_o;
  logic [NumTiles-1:0] tile_ready_o;
  logic [NumTiles-1:0] timeout_o;
  logic                busy_o;
  pwr_state_e          dbg_state_o;

  modport master (
    output en_req_i, iso_ack_i, timeout_clr_i,
    input  tile_clk_en_o, tile_rst_no, tile_iso_o, tile_ready_o, timeout_o, busy_o, dbg_state_o
  );

  modport slave (
    input  en_req_i, iso_ack_i, timeout_clr_i,
    output tile_clk_en_o, tile_rst_no, tile_iso_o, tile_ready_o, timeout_o, busy_o, dbg_state_o
  );
endinterface

// File: rtl/tile_pwr_seq_rr_arb.sv
// Round-robin first-pending search: rotate the pending mask to the pointer, then count zeros.
module tile_pwr_seq_rr_arb
  import tile_pwr_seq_pkg::*;
#(
  parameter int NumTiles = 16,
  parameter int IdxW     = idx_width(NumTiles)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumTiles-1:0] i_pend,
  input  logic                i_take,
  output logic [IdxW-1:0]     o_idx,
  output logic                o_valid
);

  logic [IdxW-1:0]       r_ptr;
  logic [2*NumTiles-1:0] w_dbl;
  logic [NumTiles-1:0]   w_rot;
  logic [NumTiles-1:0]   w_rev;
  logic [IdxW:0]         w_lz;
  logic [IdxW:0]         w_sum;

  always_comb begin
    w_dbl = {i_pend, i_pend} >> r_ptr;
    w_rot = w_dbl[NumTiles-1:0];
    for (int i = 0; i < NumTiles; i++) w_rev[i] = w_rot[NumTiles-1-i];
    // Leading zeros of the reversed mask = offset of the first pending tile from the pointer.
    w_lz = '0;
    for (int i = 0; i < NumTiles; i++) begin
      if (w_rev[i]) w_lz = (IdxW+1)'(NumTiles - 1 - i);
    end
    w_sum = {1'b0, r_ptr} + w_lz;
    if (w_sum >= (IdxW+1)'(NumTiles)) w_sum = w_sum - (IdxW+1)'(NumTiles);
    o_idx   = w_sum[IdxW-1:0];
    o_valid = |i_pend;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (i_take) begin
      r_ptr <= (o_idx == IdxW'(NumTiles - 1)) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/tile_pwr_sequencer.sv
// One shared FSM powers a single tile up or down at a time to bound inrush current.
module tile_pwr_sequencer
  import tile_pwr_seq_pkg::*;
#(
  parameter int NumTiles        = 16,
  parameter int ClkEnCycles     = 4,
  parameter int RstRelCycles    = 2,
  parameter int RstAssertCycles = 8,
  parameter int DrainTimeout    = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  tile_pwr_sequencer_if.slave  bus
);

  localparam int CntWidth = cnt_width(ClkEnCycles, RstRelCycles, RstAssertCycles, DrainTimeout);
  localparam int IdxW     = idx_width(NumTiles);
  localparam logic [CntWidth-1:0] ClkEnLast  = CntWidth'(ClkEnCycles - 1);
  localparam logic [CntWidth-1:0] RstRelLast = CntWidth'(RstRelCycles - 1);
  localparam logic [CntWidth-1:0] RstAsLast  = CntWidth'(RstAssertCycles - 1);
  localparam logic [CntWidth-1:0] DrainLast  = CntWidth'(DrainTimeout - 1);

  pwr_state_e                   r_state, w_state_nxt;
  logic [CntWidth-1:0]          r_cnt, w_cnt_nxt;
  logic [IdxW-1:0]              r_gnt;
  tile_stat_t [NumTiles-1:0]    r_stat;
  logic [NumTiles-1:0]          r_clk_en, r_rst_n, r_iso, r_ready;
  logic                         r_busy;
  logic [NumTiles-1:0]          w_on, w_tmo, w_pend;
  logic [IdxW-1:0]              w_arb_idx;
  logic                         w_arb_valid;
  logic                         w_take, w_up_go, w_dn_go;
  logic                         w_up_rst, w_up_done, w_dn_rst, w_dn_done, w_tmo_set;

  always_comb begin
    for (int i = 0; i < NumTiles; i++) begin
      w_on[i]  = r_stat[i].on;
      w_tmo[i] = r_stat[i].timeout;
    end
    w_pend = bus.en_req_i ^ w_on;
  end

  tile_pwr_seq_rr_arb #(.NumTiles(NumTiles), .IdxW(IdxW)) u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_pend  (w_pend),
    .i_take  (w_take),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_take      = 1'b0;
    w_up_rst    = 1'b0;
    w_up_done   = 1'b0;
    w_dn_rst    = 1'b0;
    w_dn_done   = 1'b0;
    w_tmo_set   = 1'b0;
    case (r_state)
      IDLE: if (w_arb_valid) begin
        w_take      = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = bus.en_req_i[w_arb_idx] ? UP_CLK : DN_ISO;
      end
      UP_CLK: if (r_cnt == ClkEnLast) begin
        w_state_nxt = UP_RST;
        w_cnt_nxt   = '0;
        w_up_rst    = 1'b1;
      end else w_cnt_nxt = r_cnt + 1'b1;
      UP_RST: if (r_cnt == RstRelLast) begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_up_done   = 1'b1;
      end else w_cnt_nxt = r_cnt + 1'b1;
      DN_ISO: if (bus.iso_ack_i[r_gnt] || r_cnt == DrainLast) begin
        // A drain that never acknowledges is forced through and flagged.
        w_tmo_set   = !bus.iso_ack_i[r_gnt];
        w_state_nxt = DN_RST;
        w_cnt_nxt   = '0;
        w_dn_rst    = 1'b1;
      end else w_cnt_nxt = r_cnt + 1'b1;
      DN_RST: if (r_cnt == RstAsLast) begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_dn_done   = 1'b1;
      end else w_cnt_nxt = r_cnt + 1'b1;
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    w_up_go = w_take &  bus.en_req_i[w_arb_idx];
    w_dn_go = w_take & ~bus.en_req_i[w_arb_idx];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      if (w_take) r_gnt <= w_arb_idx;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stat   <= '0;
      r_clk_en <= '0;
      r_rst_n  <= '0;
      r_iso    <= '1;
      r_ready  <= '0;
    end else begin
      // Set beats a coincident clear so a fresh timeout is never lost.
      for (int i = 0; i < NumTiles; i++) begin
        r_stat[i].timeout <= (r_stat[i].timeout & ~bus.timeout_clr_i[i])
                           | (w_tmo_set && (r_gnt == IdxW'(i)));
      end
      if (w_up_go) r_clk_en[w_arb_idx] <= 1'b1;
      if (w_dn_go) begin
        r_iso[w_arb_idx]   <= 1'b1;
        r_ready[w_arb_idx] <= 1'b0;
      end
      if (w_up_rst) r_rst_n[r_gnt] <= 1'b1;
      if (w_dn_rst) r_rst_n[r_gnt] <= 1'b0;
      if (w_up_done) begin
        r_iso[r_gnt]     <= 1'b0;
        r_ready[r_gnt]   <= 1'b1;
        r_stat[r_gnt].on <= 1'b1;
      end
      if (w_dn_done) begin
        r_clk_en[r_gnt]  <= 1'b0;
        r_stat[r_gnt].on <= 1'b0;
      end
    end
  end

  assign bus.tile_clk_en_o = r_clk_en;
  assign bus.tile_rst_no   = r_rst_n;
  assign bus.tile_iso_o    = r_iso;
  assign bus.tile_ready_o  = r_ready;
  assign bus.timeout_o     = w_tmo;
  assign bus.busy_o        = r_busy;
  assign bus.dbg_state_o   = r_state;

endmodule

// File: tb/tb_tile_pwr_sequencer.sv
// Directed bench for the tile power sequencer: power-up/down timing, drain timeout, arbitration, reset.
module tb_tile_pwr_sequencer;
  import tile_pwr_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  tile_pwr_sequencer_if #(.NumTiles(16)) bus ();

  tile_pwr_sequencer #(
    .NumTiles(16), .ClkEnCycles(4), .RstRelCycles(2), .RstAssertCycles(8), .DrainTimeout(16)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.en_req_i      = '0;
    bus.iso_ack_i     = '0;
    bus.timeout_clr_i = '0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic chk_safe(input string tag);
    chk({tag, "_clk_en"}, 64'(bus.tile_clk_en_o), 64'h0);
    chk({tag, "_rst_n"},  64'(bus.tile_rst_no),   64'h0);
    chk({tag, "_iso"},    64'(bus.tile_iso_o),    64'hFFFF);
    chk({tag, "_ready"},  64'(bus.tile_ready_o),  64'h0);
    chk({tag, "_tmo"},    64'(bus.timeout_o),     64'h0);
    chk({tag, "_busy"},   64'(bus.busy_o),        64'h0);
  endtask

  initial begin
    logic [16:0] m;

    // Reset and idle with no requests.
    do_reset();
    chk_safe("rst");
    tick(20);
    chk_safe("idle20");

    // Tile 3 power-up: T = this cycle.
    bus.en_req_i = 16'h0008;
    tick(1);
    chk("up3_clk_t1",  64'(bus.tile_clk_en_o), 64'h0008);
    chk("up3_rst_t1",  64'(bus.tile_rst_no),   64'h0);
    chk("up3_busy_t1", 64'(bus.busy_o),        64'h1);
    chk("up3_st_t1",   64'(bus.dbg_state_o),   64'(UP_CLK));
    tick(3);
    chk("up3_rst_t4",  64'(bus.tile_rst_no),   64'h0);
    tick(1);
    chk("up3_rst_t5",  64'(bus.tile_rst_no),   64'h0008);
    tick(1);
    chk("up3_iso_t6",  64'(bus.tile_iso_o),    64'hFFFF);
    chk("up3_rdy_t6",  64'(bus.tile_ready_o),  64'h0);
    tick(1);
    chk("up3_iso_t7",  64'(bus.tile_iso_o),    64'hFFF7);
    chk("up3_rdy_t7",  64'(bus.tile_ready_o),  64'h0008);
    chk("up3_clk_t7",  64'(bus.tile_clk_en_o), 64'h0008);
    chk("up3_busy_t7", 64'(bus.busy_o),        64'h0);
    tick(2);

    // Tile 3 power-down, ack raised at T+10.
    bus.en_req_i = 16'h0000;
    tick(1);
    chk("dn3_iso_t1",  64'(bus.tile_iso_o),    64'hFFFF);
    chk("dn3_rdy_t1",  64'(bus.tile_ready_o),  64'h0);
    chk("dn3_rst_t1",  64'(bus.tile_rst_no),   64'h0008);
    tick(8);
    chk("dn3_rst_t9",  64'(bus.tile_rst_no),   64'h0008);
    tick(1);
    bus.iso_ack_i = 16'h0008;
    tick(1);
    chk("dn3_rst_t11", 64'(bus.tile_rst_no),   64'h0);
    tick(7);
    chk("dn3_clk_t18", 64'(bus.tile_clk_en_o), 64'h0008);
    tick(1);
    chk("dn3_clk_t19", 64'(bus.tile_clk_en_o), 64'h0);
    chk("dn3_busy",    64'(bus.busy_o),        64'h0);
    chk("dn3_tmo",     64'(bus.timeout_o),     64'h0);
    bus.iso_ack_i = 16'h0000;
    tick(2);

    // Tile 5 up, then down with no ack: drain timeout after 16 DN_ISO cycles.
    bus.en_req_i = 16'h0020;
    tick(7);
    chk("up5_rdy", 64'(bus.tile_ready_o), 64'h0020);
    bus.en_req_i = 16'h0000;
    tick(16);
    chk("to5_tmo_t16", 64'(bus.timeout_o),   64'h0);
    chk("to5_rst_t16", 64'(bus.tile_rst_no), 64'h0020);
    tick(1);
    chk("to5_tmo_t17", 64'(bus.timeout_o),   64'h0020);
    chk("to5_rst_t17", 64'(bus.tile_rst_no), 64'h0);
    tick(7);
    chk("to5_clk_t24", 64'(bus.tile_clk_en_o), 64'h0020);
    tick(1);
    chk("to5_clk_t25", 64'(bus.tile_clk_en_o), 64'h0);
    chk("to5_busy",    64'(bus.busy_o),        64'h0);
    chk("to5_sticky",  64'(bus.timeout_o),     64'h0020);
    bus.timeout_clr_i = 16'h0020;
    tick(1);
    bus.timeout_clr_i = 16'h0000;
    chk("to5_cleared", 64'(bus.timeout_o), 64'h0);
    tick(1);

    // Clear coincident with a new timeout set: set wins.
    bus.en_req_i = 16'h0020;
    tick(7);
    bus.en_req_i = 16'h0000;
    tick(16);
    bus.timeout_clr_i = 16'h0020;
    tick(1);
    bus.timeout_clr_i = 16'h0000;
    chk("to5_set_wins", 64'(bus.timeout_o), 64'h0020);
    tick(8);
    chk("to5b_busy", 64'(bus.busy_o), 64'h0);

    // All tiles requested at once: strict order 0..15, one IDLE cycle between.
    do_reset();
    chk_safe("rst2");
    bus.en_req_i = 16'hFFFF;
    for (int k = 0; k < 16; k++) begin
      tick(1);
      m = (17'd1 << (k + 1)) - 17'd1;
      chk("all_clk_en", 64'(bus.tile_clk_en_o), 64'(m[15:0]));
      tick(6);
      chk("all_ready", 64'(bus.tile_ready_o), 64'(m[15:0]));
      chk("all_idle",  64'(bus.dbg_state_o),  64'(IDLE));
    end

    // Power tile 6 down to park the pointer at 7, then make 2 and 9 pending together.
    bus.iso_ack_i = 16'hFFFF;
    bus.en_req_i  = 16'hFFBF;
    tick(1);
    chk("dn6_iso", 64'(bus.tile_iso_o), 64'h0040);
    tick(9);
    chk("dn6_clk",  64'(bus.tile_clk_en_o), 64'hFFBF);
    chk("dn6_busy", 64'(bus.busy_o),        64'h0);
    tick(2);
    bus.en_req_i = 16'hFDBB;
    tick(1);
    chk("rr_first9", 64'(bus.tile_iso_o), 64'h0240);
    tick(9);
    chk("rr_9done_iso", 64'(bus.tile_iso_o),    64'h0240);
    chk("rr_9done_clk", 64'(bus.tile_clk_en_o), 64'hFDBF);
    tick(1);
    chk("rr_then2", 64'(bus.tile_iso_o), 64'h0244);
    tick(12);

    // Tile 4 glitch and tile 1 drop during tile 1's power-up.
    do_reset();
    bus.iso_ack_i = 16'h0002;
    bus.en_req_i  = 16'h0002;
    tick(1);
    chk("gl_clk_t1", 64'(bus.tile_clk_en_o), 64'h0002);
    bus.en_req_i = 16'h0012;
    tick(1);
    bus.en_req_i = 16'h0002;
    tick(1);
    bus.en_req_i = 16'h0000;
    tick(4);
    chk("gl_rdy_t7", 64'(bus.tile_ready_o),  64'h0002);
    chk("gl_iso_t7", 64'(bus.tile_iso_o),    64'hFFFD);
    chk("gl_clk_t7", 64'(bus.tile_clk_en_o), 64'h0002);
    tick(1);
    chk("gl_iso_t8", 64'(bus.tile_iso_o),    64'hFFFF);
    chk("gl_rdy_t8", 64'(bus.tile_ready_o),  64'h0);
    chk("gl_st_t8",  64'(bus.dbg_state_o),   64'(DN_ISO));
    tick(1);
    chk("gl_rst_t9", 64'(bus.tile_rst_no), 64'h0);
    tick(8);
    chk("gl_clk_t17",  64'(bus.tile_clk_en_o), 64'h0);
    chk("gl_busy_t17", 64'(bus.busy_o),        64'h0);
    tick(3);
    chk("gl_no4_clk",  64'(bus.tile_clk_en_o), 64'h0);
    chk("gl_no4_busy", 64'(bus.busy_o),        64'h0);

    // Asynchronous reset in the middle of UP_RST.
    bus.en_req_i = 16'h0001;
    tick(5);
    chk("ar_rst_t5", 64'(bus.tile_rst_no), 64'h0001);
    chk("ar_st_t5",  64'(bus.dbg_state_o), 64'(UP_RST));
    rst = 1'b1;
    #2;
    chk_safe("async_rst");
    chk("ar_st", 64'(bus.dbg_state_o), 64'(IDLE));
    bus.en_req_i = 16'h0000;
    tick(1);
    rst = 1'b0;
    tick(3);
    chk_safe("after_ar");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
